accel_pcpi_responder: RTL

- PCPI-side responder that connects the PicoRV32 core to the matrix accelerator.
- Decodes custom-0 instructions and loads A/B operand words into local register banks.
- Issues a single-cycle start_req to the accelerator, stalls the CPU with pcpi_wait until done, then returns result words or status through pcpi_rd.
- Sits between the core's PCPI port and the accelerator's start_req/memA/memB/done/result_flat interface.

---
 rtl/accel_pcpi_pkg.sv | 25 ++
 rtl/accel_pcpi_decoder.sv | 19 +
 rtl/accel_pcpi_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/accel_pcpi_pkg.sv
// Shared opcode, operation, state and status-bit definitions for the PCPI accelerator responder.
package accel_pcpi_pkg;

   localparam logic [6:0] OPC_CUSTOM0 = 7'b0001011;

   typedef enum logic [6:0] {
      OP_LDA    = 7'd0,
      OP_LDB    = 7'd1,
      OP_START  = 7'd2,
      OP_RDC    = 7'd3,
      OP_STATUS = 7'd4
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_RESP,
      S_COOL
   } state_e;

   localparam int ST_BUSY = 0;
   localparam int ST_DONE = 1;
   localparam int ST_ERR  = 2;

endpackage

// File: rtl/accel_pcpi_decoder.sv
// Combinational custom-0 match and funct7 operation decode; zero latency, no flow control.
module accel_pcpi_decoder
   import accel_pcpi_pkg::*;
(
   input  logic [31:0] insn,
   output logic        match,
   output op_e         op
);

   logic unused_fields;

   assign op    = op_e'(insn[31:25]);
   assign match = (insn[6:0] == OPC_CUSTOM0) && (insn[14:12] == 3'b000) &&
                  (insn[31:25] <= OP_STATUS);

   // Register-specifier fields carry no meaning for this responder.
   assign unused_fields = ^{insn[24:15], insn[11:7]};

endmodule

// File: rtl/accel_pcpi_responder.sv
// PCPI responder feeding the matrix accelerator: loads/reads answer one cycle after accept,
// START stalls the CPU via pcpi_wait until done or timeout; pcpi_valid is ignored during the cool-down cycle.
module accel_pcpi_responder
   import accel_pcpi_pkg::*;
#(
   parameter int N       = 4,
   parameter int W       = 32,
   parameter int TIMEOUT = 1024
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pcpi_valid,
   input  logic [31:0]      pcpi_insn,
   input  logic [31:0]      pcpi_rs1,
   input  logic [31:0]      pcpi_rs2,
   output logic             pcpi_wr,
   output logic [31:0]      pcpi_rd,
   output logic             pcpi_wait,
   output logic             pcpi_ready,
   output logic [N*N*W-1:0] memA_flat,
   output logic [N*N*W-1:0] memB_flat,
   output logic             start_req,
   input  logic             done,
   input  logic [N*N*W-1:0] result_flat
);

   localparam int IW = $clog2(N*N);

   state_e             state, state_nxt;
   logic               match;
   op_e                op;
   logic               accept;
   logic               abandon;
   logic [IW-1:0]      idx_rs1, idx_rs2;
   logic [N*N*W-1:0]   bank_a, bank_b;
   logic [31:0]        count;
   logic [31:0]        resp_rd;
   logic               resp_wr;
   logic               err, done_sticky, dropped;
   logic [31:0]        status;
   logic               unused_bits;

   accel_pcpi_decoder u_dec (
      .insn  (pcpi_insn),
      .match (match),
      .op    (op)
   );

   assign idx_rs1     = pcpi_rs1[IW-1:0];
   assign idx_rs2     = pcpi_rs2[IW-1:0];
   assign unused_bits = ^{pcpi_rs1, pcpi_rs2};

   // A CPU that let go of pcpi_valid mid-run gets no ready pulse for this START.
   assign abandon = dropped || !pcpi_valid;

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      case (state)
         S_IDLE: begin
            if (pcpi_valid && match) begin
               accept    = 1'b1;
               state_nxt = (op == OP_START) ? S_RUN : S_RESP;
            end
         end
         S_RUN: begin
            if (done || (count == TIMEOUT - 1))
               state_nxt = abandon ? S_COOL : S_RESP;
         end
         S_RESP:  state_nxt = S_COOL;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      status          = '0;
      status[ST_BUSY] = (state == S_RUN);
      status[ST_DONE] = done_sticky;
      status[ST_ERR]  = err;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         bank_a      <= '0;
         bank_b      <= '0;
         count       <= '0;
         resp_rd     <= '0;
         resp_wr     <= 1'b0;
         err         <= 1'b0;
         done_sticky <= 1'b0;
         dropped     <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            resp_wr <= (op != OP_LDA) && (op != OP_LDB);
            resp_rd <= '0;
            case (op)
               OP_LDA:    bank_a[int'(idx_rs2)*W +: W] <= pcpi_rs1[W-1:0];
               OP_LDB:    bank_b[int'(idx_rs2)*W +: W] <= pcpi_rs1[W-1:0];
               OP_START: begin
                  count       <= '0;
                  err         <= 1'b0;
                  done_sticky <= 1'b0;
                  dropped     <= 1'b0;
               end
               OP_RDC:    resp_rd <= 32'(result_flat[int'(idx_rs1)*W +: W]);
               OP_STATUS: resp_rd <= status;
               default:   ;
            endcase
         end
         if (state == S_RUN) begin
            count <= count + 32'd1;
            if (!pcpi_valid)
               dropped <= 1'b1;
            // done takes priority over a timeout expiring in the same cycle.
            if (done) begin
               resp_rd     <= count;
               done_sticky <= 1'b1;
            end else if (count == TIMEOUT - 1) begin
               resp_rd <= '1;
               err     <= 1'b1;
            end
         end
      end
   end

   assign pcpi_ready = (state == S_RESP);
   assign pcpi_wait  = (state == S_RUN);
   assign pcpi_wr    = pcpi_ready && resp_wr;
   assign pcpi_rd    = pcpi_ready ? resp_rd : 32'd0;
   assign start_req  = (state == S_RUN) && (count == 32'd0);
   assign memA_flat  = bank_a;
   assign memB_flat  = bank_b;

endmodule
